// File: rtl/stopwatch_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_mode_controller
//  Description : Debounces the two active-low mode keys, steps a 4-state
//                mode FSM, divides the clock into a 1 s tick and issues one
//                clear/inc/dec command per tick to the external counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_mode_controller #(
  parameter logic [25:0] TICK_INTERVAL   = 26'd49_999_999,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd999_999
) (
  input  logic        in_clk,
  input  logic        global_reset,
  input  logic        in_button_up_n,
  input  logic        in_button_down_n,
  input  logic [15:0] in_count_value,
  output logic [1:0]  out_state,
  output logic        out_tick,
  output logic        out_cmd_clear,
  output logic        out_cmd_inc,
  output logic        out_cmd_dec,
  output logic        out_saturated
);

  localparam logic [1:0] c_ST_CLEAR      = 2'b00;
  localparam logic [1:0] c_ST_COUNT_UP   = 2'b01;
  localparam logic [1:0] c_ST_COUNT_DOWN = 2'b10;
  localparam logic [1:0] c_ST_HOLD       = 2'b11;

  // Index 0 is the up key, index 1 the down key.
  logic [1:0]  w_key_n;
  logic [1:0]  w_press;

  logic [1:0]  r_state;
  logic [25:0] r_presc;
  logic        r_tick;
  logic        r_cmd_clear;
  logic        r_cmd_inc;
  logic        r_cmd_dec;
  logic        r_saturated;

  logic        w_go_up;
  logic        w_go_down;
  logic        w_state_change;

  assign w_key_n = {in_button_down_n, in_button_up_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_button
    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_level_q;
    logic [19:0] r_db_cnt;
    logic        w_sample;

    // Synchronized key, flipped so that 1 means pressed.
    assign w_sample = ~r_sync2;

    // Synchronize the key and accept a new level only after it has held long enough.
    always_ff @(posedge in_clk) begin
      if (global_reset) begin
        r_sync1   <= 1'b1;
        r_sync2   <= 1'b1;
        r_level   <= 1'b0;
        r_level_q <= 1'b0;
        r_db_cnt  <= '0;
      end else begin
        r_sync1   <= w_key_n[gi];
        r_sync2   <= r_sync1;
        r_level_q <= r_level;
        if (w_sample == r_level) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DEBOUNCE_CYCLES) begin
          r_level  <= w_sample;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 20'd1;
        end
      end
    end

    // Only the press edge matters; releases are ignored.
    assign w_press[gi] = r_level & ~r_level_q;
  end

  // Simultaneous up and down presses cancel; the ends of the mode range saturate.
  assign w_go_up        = w_press[0] & ~w_press[1] & (r_state != c_ST_HOLD);
  assign w_go_down      = w_press[1] & ~w_press[0] & (r_state != c_ST_CLEAR);
  assign w_state_change = w_go_up | w_go_down;

  // Mode FSM.
  always_ff @(posedge in_clk) begin
    if (global_reset) begin
      r_state <= c_ST_CLEAR;
    end else if (w_go_up) begin
      r_state <= r_state + 2'd1;
    end else if (w_go_down) begin
      r_state <= r_state - 2'd1;
    end
  end

  // Prescaler; a mode change restarts the tick period and suppresses a coincident tick.
  always_ff @(posedge in_clk) begin
    if (global_reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (w_state_change) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (r_presc == TICK_INTERVAL) begin
      r_presc <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_presc <= r_presc + 26'd1;
      r_tick  <= 1'b0;
    end
  end

  // One command per tick, chosen from the mode held during the tick cycle.
  always_ff @(posedge in_clk) begin
    if (global_reset) begin
      r_cmd_clear <= 1'b0;
      r_cmd_inc   <= 1'b0;
      r_cmd_dec   <= 1'b0;
      r_saturated <= 1'b0;
    end else begin
      r_cmd_clear <= 1'b0;
      r_cmd_inc   <= 1'b0;
      r_cmd_dec   <= 1'b0;
      if (r_tick) begin
        case (r_state)
          c_ST_CLEAR: begin
            r_cmd_clear <= 1'b1;
            r_saturated <= 1'b0;
          end
          c_ST_COUNT_UP: begin
            if (in_count_value != 16'hFFFF) begin
              r_cmd_inc   <= 1'b1;
              r_saturated <= 1'b0;
            end else begin
              r_saturated <= 1'b1;
            end
          end
          c_ST_COUNT_DOWN: begin
            if (in_count_value != 16'h0000) begin
              r_cmd_dec   <= 1'b1;
              r_saturated <= 1'b0;
            end else begin
              r_saturated <= 1'b1;
            end
          end
          default: begin
            r_cmd_clear <= 1'b0;
          end
        endcase
      end
      // A mode change starts afresh, so any earlier blocked command is forgotten.
      if (w_state_change) begin
        r_saturated <= 1'b0;
      end
    end
  end

  assign out_state     = r_state;
  assign out_tick      = r_tick;
  assign out_cmd_clear = r_cmd_clear;
  assign out_cmd_inc   = r_cmd_inc;
  assign out_cmd_dec   = r_cmd_dec;
  assign out_saturated = r_saturated;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_mode_controller
//  Description : Self-checking bench for stopwatch_mode_controller with
//                TICK_INTERVAL=3 and DEBOUNCE_CYCLES=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_mode_controller;

  logic        in_clk = 1'b0;
  logic        global_reset;
  logic        in_button_up_n;
  logic        in_button_down_n;
  logic [15:0] in_count_value;
  logic [1:0]  out_state;
  logic        out_tick;
  logic        out_cmd_clear;
  logic        out_cmd_inc;
  logic        out_cmd_dec;
  logic        out_saturated;

  stopwatch_mode_controller #(
    .TICK_INTERVAL  (26'd3),
    .DEBOUNCE_CYCLES(20'd2)
  ) dut (
    .in_clk          (in_clk),
    .global_reset    (global_reset),
    .in_button_up_n  (in_button_up_n),
    .in_button_down_n(in_button_down_n),
    .in_count_value  (in_count_value),
    .out_state       (out_state),
    .out_tick        (out_tick),
    .out_cmd_clear   (out_cmd_clear),
    .out_cmd_inc     (out_cmd_inc),
    .out_cmd_dec     (out_cmd_dec),
    .out_saturated   (out_saturated)
  );

  always #5 in_clk = ~in_clk;

  typedef struct packed {
    logic [1:0] state;
    logic       tick;
    logic       clr;
    logic       inc;
    logic       dec;
    logic       sat;
  } out_t;

  typedef struct {
    logic        up_n;
    logic        down_n;
    logic [15:0] cnt;
    int          cycles;
    logic [1:0]  st;
    logic        sat;
  } vec_t;

  out_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state
  logic       m_s1[2];
  logic       m_s2[2];
  logic       m_lvl[2];
  logic       m_prev[2];
  int         m_cnt[2];
  logic [1:0] m_state;
  int         m_presc;
  logic       m_tick, m_clr, m_inc, m_dec, m_sat;

  task automatic model_step();
    logic [1:0] key_n;
    logic [1:0] pr;
    logic [1:0] nxt;
    logic       smp;
    key_n = {in_button_down_n, in_button_up_n};
    if (global_reset) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1'b1; m_s2[b] = 1'b1; m_lvl[b] = 1'b0; m_prev[b] = 1'b0; m_cnt[b] = 0;
      end
      m_state = 2'b00; m_presc = 0; m_tick = 0; m_clr = 0; m_inc = 0; m_dec = 0; m_sat = 0;
    end else begin
      for (int b = 0; b < 2; b++) pr[b] = m_lvl[b] & ~m_prev[b];
      nxt = m_state;
      if (pr[0] && !pr[1] && m_state != 2'b11) nxt = m_state + 2'd1;
      else if (pr[1] && !pr[0] && m_state != 2'b00) nxt = m_state - 2'd1;
      m_clr = 0; m_inc = 0; m_dec = 0;
      if (m_tick) begin
        if (m_state == 2'b00) begin m_clr = 1; m_sat = 0; end
        else if (m_state == 2'b01) begin
          if (in_count_value == 16'hFFFF) m_sat = 1; else begin m_inc = 1; m_sat = 0; end
        end else if (m_state == 2'b10) begin
          if (in_count_value == 16'h0000) m_sat = 1; else begin m_dec = 1; m_sat = 0; end
        end
      end
      if (nxt != m_state) begin
        m_sat = 0; m_presc = 0; m_tick = 0;
      end else if (m_presc == 3) begin
        m_presc = 0; m_tick = 1;
      end else begin
        m_presc = m_presc + 1; m_tick = 0;
      end
      m_state = nxt;
      for (int b = 0; b < 2; b++) begin
        smp = ~m_s2[b];
        m_prev[b] = m_lvl[b];
        if (smp == m_lvl[b]) m_cnt[b] = 0;
        else if (m_cnt[b] == 2) begin m_lvl[b] = smp; m_cnt[b] = 0; end
        else m_cnt[b] = m_cnt[b] + 1;
        m_s2[b] = m_s1[b];
        m_s1[b] = key_n[b];
      end
    end
  endtask

  task automatic check_outputs();
    out_t got, e;
    got = {out_state, out_tick, out_cmd_clear, out_cmd_inc, out_cmd_dec, out_saturated};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty cycle %0d: got %b, no expected entry", cyc, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs cycle %0d: got st/tk/clr/inc/dec/sat=%b required %b", cyc, got, e);
      end
    end
  endtask

  // One clock: model advances with the DUT at the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge in_clk);
    model_step();
    exp_q.push_back({m_state, m_tick, m_clr, m_inc, m_dec, m_sat});
    @(negedge in_clk);
    cyc++;
    check_outputs();
  endtask

  vec_t tbl[25];

  initial begin
    int k;
    tbl[0]  = '{1'b1, 1'b1, 16'h0005, 20, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'h0005,  2, 2'b00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'h0005, 10, 2'b00, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 16'h0005,  8, 2'b01, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 16'h0005,  8, 2'b01, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'h0005,  8, 2'b10, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 16'h0005,  8, 2'b10, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'h0005,  8, 2'b11, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 16'h0005,  8, 2'b11, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'h0005,  8, 2'b11, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 16'h0005,  8, 2'b11, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 16'h0005,  8, 2'b10, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 16'h0005,  8, 2'b10, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 16'h0005,  8, 2'b01, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 16'h0005,  8, 2'b01, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 16'hFFFF, 12, 2'b01, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 16'hFFFF,  8, 2'b00, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 16'hFFFF,  8, 2'b00, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 16'h0005,  8, 2'b01, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 16'h0005,  8, 2'b01, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 16'h0005,  8, 2'b10, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 16'h0005, 12, 2'b10, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 16'h0000, 12, 2'b10, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 16'h0000,  8, 2'b10, 1'b1};
    tbl[24] = '{1'b1, 1'b1, 16'h0000,  8, 2'b10, 1'b1};

    global_reset     = 1'b1;
    in_button_up_n   = 1'b1;
    in_button_down_n = 1'b1;
    in_count_value   = 16'h0005;
    repeat (3) cycle();

    n_tests++;
    if ({out_state, out_tick, out_cmd_clear, out_cmd_inc, out_cmd_dec, out_saturated} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b%b%b%b%b%b required 0000000", out_state, out_tick,
               out_cmd_clear, out_cmd_inc, out_cmd_dec, out_saturated);
    end
    global_reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      in_button_up_n   = tbl[i].up_n;
      in_button_down_n = tbl[i].down_n;
      in_count_value   = tbl[i].cnt;
      repeat (tbl[i].cycles) cycle();
      n_tests++;
      if (out_state !== tbl[i].st || out_saturated !== tbl[i].sat) begin
        n_fail++;
        $display("FAIL vector_%0d: got state=%b sat=%b required state=%b sat=%b",
                 i, out_state, out_saturated, tbl[i].st, tbl[i].sat);
      end
    end

    // Reset asserted while the tick strobe is high: next cycle everything is 0.
    k = 0;
    while (out_tick !== 1'b1 && k < 10) begin
      cycle();
      k++;
    end
    n_tests++;
    if (out_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_tick: got tick=%b required 1 within 10 cycles", out_tick);
    end
    global_reset = 1'b1;
    cycle();
    n_tests++;
    if ({out_state, out_tick, out_cmd_clear, out_cmd_inc, out_cmd_dec, out_saturated} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid_tick: got %b%b%b%b%b%b required 0000000", out_state, out_tick,
               out_cmd_clear, out_cmd_inc, out_cmd_dec, out_saturated);
    end
    global_reset = 1'b0;

    // First tick after reset arrives on the 4th edge, the clear command one edge later.
    k = 0;
    do begin
      cycle();
      k++;
    end while (out_tick !== 1'b1 && k < 10);
    n_tests++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL first_tick_latency: got %0d cycles required 4", k);
    end
    cycle();
    n_tests++;
    if (out_cmd_clear !== 1'b1 || out_state !== 2'b00 || out_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_after_tick: got clr=%b state=%b tick=%b required clr=1 state=00 tick=0",
               out_cmd_clear, out_state, out_tick);
    end
    repeat (8) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
